uart_sys_top: RTL and testbench
===============================

UART_SYS_TOP -- requirements
Module: uart_sys_top

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16; Ref_clk cycles per UART bit; legal range 8..1023.
REQ-002 SHALL have port Ref_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port rx_in, input, 1, asynchronous UART serial input; idle high.
REQ-005 SHALL have port tx_out, output, 1, UART serial output; idle high.
REQ-006 SHALL have port stop_error, output, 1, one-cycle pulse when a received stop bit samples 0.
REQ-007 SHALL have port parity_error, output, 1, one-cycle pulse when received parity mismatches.
REQ-008 SHALL have port start_glitch, output, 1, one-cycle pulse when the start bit is not 0 at mid-bit.

Function
REQ-009 SHALL pass rx_in through a 2-flop synchronizer before use.
REQ-010 SHALL use frame format: start 0, 8 data bits LSB first, even-parity bit, stop 1 (same for RX and TX).
REQ-011 SHALL detect the RX start on a 1->0 transition and re-sample at CLKS_PER_BIT/2; if high -> pulse start_glitch, no byte, return idle.
REQ-012 SHALL sample each later RX bit once at its mid-bit; a byte is valid only if parity and stop are correct.
REQ-013 SHALL discard a byte with a parity or stop error and return the command FSM to IDLE.
REQ-014 SHALL keep a 16 x 8 register file, addressed by the low 4 bits of the address byte; reg0 = operand A, reg1 = operand B.
REQ-015 SHALL run command FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC.
REQ-016 SHALL, in IDLE, decode 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_A, 0xDD->ALU_FUNC; any other byte is ignored and the FSM stays in IDLE.
REQ-017 SHALL handle 0xAA as: address byte, then data byte; write regfile[addr]=data; no response.
REQ-018 SHALL handle 0xBB as: address byte; enqueue regfile[addr] as one TX byte.
REQ-019 SHALL handle 0xCC as: A byte written to reg0, B byte written to reg1, then FUNC byte; execute.
REQ-020 SHALL handle 0xDD as: FUNC byte; execute using the current reg0/reg1.
REQ-021 SHALL compute a 16-bit ALU result with operands zero-extended: 0 A+B; 1 A-B mod 2^16; 2 A*B; 3 A/B integer, with B=0 giving 0; 4 A&B; 5 A|B; 6 A^B; any other FUNC gives 0.
REQ-022 SHALL enqueue the ALU result as two TX bytes, low byte first, 1 cycle after FUNC is accepted.
REQ-023 SHALL provide a 4-byte TX FIFO so commands are accepted while TX is busy; bytes are sent back to back with no idle gap.
REQ-024 SHALL drop an enqueue attempted while the FIFO is full.
REQ-025 SHALL keep FIFO pointers as 2-bit wrap-around indices plus a 3-bit count.

Reset
REQ-026 SHALL, while rst is high, set: tx_out=1; stop_error=parity_error=start_glitch=0; FSM=IDLE; FIFO empty; RX and TX idle; all registers 0x00.
REQ-027 SHALL, on reset mid-frame, abort RX/TX immediately; the partial frame is never completed or resumed.

Configuration
REQ-028 SHALL, with macro UART_SYS_TOP_PARITY_EN defined, include the parity bit (11-bit frames) on RX and TX.
REQ-029 SHALL, without UART_SYS_TOP_PARITY_EN, use 10-bit frames with no parity bit and tie parity_error to 0.

Verification (parity enabled)
REQ-030 SHALL pass: rx low for 1 Ref_clk, then high -> start_glitch pulses once; no FIFO entry; FSM stays IDLE.
REQ-031 SHALL pass: frames AA,05,19 then BB,05 -> TX byte 0x19; then BB,02 -> TX 0x00.
REQ-032 SHALL pass: CC,0B,0F,00 -> TX 1A,00; CC,0A,0F,01 -> FB,FF; CC,96,59,02 -> 26,34; CC,C8,04,03 -> 32,00; CC,0A,0F,04 -> 0A,00.
REQ-033 SHALL pass: AA,00,7F; AA,01,FD; then DD,00 -> 7C,01; DD,01 -> 82,FF; DD,02 -> 83,7D; DD,03 -> 00,00; DD,04 -> 7D,00.
REQ-034 SHALL pass: byte 0xAA sent with the wrong parity bit -> parity_error pulses; the following 05,19 is not treated as a write.
REQ-035 SHALL pass: a frame with stop=0 -> stop_error pulses and the byte is discarded; DD,03 with reg1=0 -> 00,00.

Source files
------------

// File: rtl/uart_sys_top.sv
// UART command/ALU system: RX deframer, command FSM with 16x8 register file, ALU, 4-deep TX FIFO and TX framer.
// Define UART_SYS_TOP_PARITY_EN for 11-bit frames with even parity; otherwise 10-bit frames.
module uart_sys_top #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic Ref_clk,
  input  logic rst,
  input  logic rx_in,
  output logic tx_out,
  output logic stop_error,
  output logic parity_error,
  output logic start_glitch
);

`ifdef UART_SYS_TOP_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    TX_BITS  = PAR_EN ? 4'd10 : 4'd9;

  localparam logic [2:0] R_IDLE = 3'd0, R_START = 3'd1, R_DATA = 3'd2, R_PAR = 3'd3, R_STOP = 3'd4;
  localparam logic [2:0] C_IDLE = 3'd0, C_WR_ADDR = 3'd1, C_WR_DATA = 3'd2, C_RD_ADDR = 3'd3,
                         C_ALU_A = 3'd4, C_ALU_B = 3'd5, C_ALU_FUNC = 3'd6;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_pbad_q, rx_pbad_d;
  logic          byte_vld_q, byte_vld_d, stop_err_q, stop_err_d;
  logic          par_err_q, par_err_d, glitch_q, glitch_d;

  logic [2:0]    cmd_st_q, cmd_st_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    func_q, func_d;
  logic          alu_go_q, alu_go_d, hi_pend_q, hi_pend_d;
  logic [7:0]    hi_q, hi_d;
  logic [7:0]    rf_q [16];
  logic          rf_we_c;
  logic [3:0]    rf_wa_c;
  logic [7:0]    rf_wd_c;
  logic          push_c;
  logic [7:0]    push_data_c;
  logic [15:0]   alu_res_c;

  logic [7:0]    fifo_q [4];
  logic [1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    fifo_cnt_q, fifo_cnt_d;
  logic          push_ok_c, pop_c, tx_bit_end_c;
  logic [7:0]    tx_data_c;
  logic [9:0]    tx_frame_c;
  logic          tx_busy_q, tx_busy_d, tx_out_q, tx_out_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [3:0]    tx_left_q, tx_left_d;

  // RX deframer: edge detect, mid-bit sampling, frame checks
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_pbad_d  = rx_pbad_q;
    byte_vld_d = 1'b0;
    stop_err_d = 1'b0;
    par_err_d  = 1'b0;
    glitch_d   = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d  = '0;
        rx_pbad_d = 1'b0;
        if (rx_prev_q && !rx_sync_q) rx_st_d = R_START;
      end
      R_START: if (rx_cnt_q == BIT_HALF) begin
        rx_cnt_d = '0;
        rx_bit_d = 3'd0;
        if (!rx_sync_q) rx_st_d = R_DATA;
        else begin
          glitch_d = 1'b1;
          rx_st_d  = R_IDLE;
        end
      end
      R_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = PAR_EN ? R_PAR : R_STOP;
      end
      R_PAR: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d  = '0;
        rx_pbad_d = rx_sync_q ^ (^rx_sh_q);
        rx_st_d   = R_STOP;
      end
      R_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_st_d    = R_IDLE;
        stop_err_d = !rx_sync_q;
        par_err_d  = PAR_EN && rx_pbad_q;
        byte_vld_d = rx_sync_q && !(PAR_EN && rx_pbad_q);
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  always_comb begin
    case (func_q)
      8'd0:    alu_res_c = {8'h00, rf_q[0]} + {8'h00, rf_q[1]};
      8'd1:    alu_res_c = {8'h00, rf_q[0]} - {8'h00, rf_q[1]};
      8'd2:    alu_res_c = {8'h00, rf_q[0]} * {8'h00, rf_q[1]};
      8'd3:    alu_res_c = (rf_q[1] == 8'h00) ? 16'h0000 : {8'h00, rf_q[0] / rf_q[1]};
      8'd4:    alu_res_c = {8'h00, rf_q[0] & rf_q[1]};
      8'd5:    alu_res_c = {8'h00, rf_q[0] | rf_q[1]};
      8'd6:    alu_res_c = {8'h00, rf_q[0] ^ rf_q[1]};
      default: alu_res_c = 16'h0000;
    endcase
  end

  // Command FSM; the ALU result goes out low byte then high byte on consecutive cycles
  always_comb begin
    cmd_st_d    = cmd_st_q;
    addr_d      = addr_q;
    func_d      = func_q;
    alu_go_d    = 1'b0;
    hi_pend_d   = 1'b0;
    hi_d        = hi_q;
    rf_we_c     = 1'b0;
    rf_wa_c     = 4'd0;
    rf_wd_c     = 8'h00;
    push_c      = 1'b0;
    push_data_c = 8'h00;
    if (alu_go_q) begin
      push_c      = 1'b1;
      push_data_c = alu_res_c[7:0];
      hi_d        = alu_res_c[15:8];
      hi_pend_d   = 1'b1;
    end else if (hi_pend_q) begin
      push_c      = 1'b1;
      push_data_c = hi_q;
    end
    if (stop_err_q || par_err_q) begin
      cmd_st_d = C_IDLE;
    end else if (byte_vld_q) begin
      case (cmd_st_q)
        C_IDLE: case (rx_sh_q)
          8'hAA:   cmd_st_d = C_WR_ADDR;
          8'hBB:   cmd_st_d = C_RD_ADDR;
          8'hCC:   cmd_st_d = C_ALU_A;
          8'hDD:   cmd_st_d = C_ALU_FUNC;
          default: cmd_st_d = C_IDLE;
        endcase
        C_WR_ADDR: begin
          addr_d   = rx_sh_q[3:0];
          cmd_st_d = C_WR_DATA;
        end
        C_WR_DATA: begin
          rf_we_c  = 1'b1;
          rf_wa_c  = addr_q;
          rf_wd_c  = rx_sh_q;
          cmd_st_d = C_IDLE;
        end
        C_RD_ADDR: begin
          push_c      = 1'b1;
          push_data_c = rf_q[rx_sh_q[3:0]];
          cmd_st_d    = C_IDLE;
        end
        C_ALU_A: begin
          rf_we_c  = 1'b1;
          rf_wa_c  = 4'd0;
          rf_wd_c  = rx_sh_q;
          cmd_st_d = C_ALU_B;
        end
        C_ALU_B: begin
          rf_we_c  = 1'b1;
          rf_wa_c  = 4'd1;
          rf_wd_c  = rx_sh_q;
          cmd_st_d = C_ALU_FUNC;
        end
        C_ALU_FUNC: begin
          func_d   = rx_sh_q;
          alu_go_d = 1'b1;
          cmd_st_d = C_IDLE;
        end
        default: cmd_st_d = C_IDLE;
      endcase
    end
  end

  // TX FIFO and framer; the next frame loads on the last cycle of the stop bit
  always_comb begin
    push_ok_c    = push_c && (fifo_cnt_q != 3'd4);
    tx_bit_end_c = tx_busy_q && (tx_cnt_q == BIT_LAST);
    pop_c        = (fifo_cnt_q != 3'd0) && (!tx_busy_q || (tx_bit_end_c && tx_left_q == 4'd0));
    tx_data_c    = fifo_q[rd_ptr_q];
    tx_frame_c   = PAR_EN ? {1'b1, ^tx_data_c, tx_data_c} : {2'b11, tx_data_c};
    wr_ptr_d     = push_ok_c ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d     = pop_c ? rd_ptr_q + 2'd1 : rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q + 3'(push_ok_c) - 3'(pop_c);
    tx_busy_d    = tx_busy_q;
    tx_out_d     = tx_out_q;
    tx_sh_d      = tx_sh_q;
    tx_left_d    = tx_left_q;
    tx_cnt_d     = tx_busy_q ? tx_cnt_q + CW'(1) : '0;
    if (pop_c) begin
      tx_busy_d = 1'b1;
      tx_out_d  = 1'b0;
      tx_sh_d   = tx_frame_c;
      tx_left_d = TX_BITS;
      tx_cnt_d  = '0;
    end else if (tx_bit_end_c) begin
      tx_cnt_d = '0;
      if (tx_left_q != 4'd0) begin
        tx_out_d  = tx_sh_q[0];
        tx_sh_d   = {1'b1, tx_sh_q[9:1]};
        tx_left_d = tx_left_q - 4'd1;
      end else begin
        tx_busy_d = 1'b0;
        tx_out_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Ref_clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_pbad_q  <= 1'b0;
      byte_vld_q <= 1'b0;
      stop_err_q <= 1'b0;
      par_err_q  <= 1'b0;
      glitch_q   <= 1'b0;
      cmd_st_q   <= C_IDLE;
      addr_q     <= 4'd0;
      func_q     <= 8'h00;
      alu_go_q   <= 1'b0;
      hi_pend_q  <= 1'b0;
      hi_q       <= 8'h00;
      for (int i = 0; i < 16; i++) rf_q[i] <= 8'h00;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 8'h00;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 3'd0;
      tx_busy_q  <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '1;
      tx_left_q  <= 4'd0;
    end else begin
      rx_meta_q  <= rx_in;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pbad_q  <= rx_pbad_d;
      byte_vld_q <= byte_vld_d;
      stop_err_q <= stop_err_d;
      par_err_q  <= par_err_d;
      glitch_q   <= glitch_d;
      cmd_st_q   <= cmd_st_d;
      addr_q     <= addr_d;
      func_q     <= func_d;
      alu_go_q   <= alu_go_d;
      hi_pend_q  <= hi_pend_d;
      hi_q       <= hi_d;
      if (rf_we_c) rf_q[rf_wa_c] <= rf_wd_c;
      if (push_ok_c) fifo_q[wr_ptr_q] <= push_data_c;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      tx_busy_q  <= tx_busy_d;
      tx_out_q   <= tx_out_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_left_q  <= tx_left_d;
    end
  end

  assign tx_out       = tx_out_q;
  assign stop_error   = stop_err_q;
  assign parity_error = PAR_EN & par_err_q;
  assign start_glitch = glitch_q;

endmodule

// File: tb/tb_uart_sys_top.sv
// Scoreboard bench for uart_sys_top: drives UART command frames, decodes tx_out and checks bytes and error pulses.
module tb_uart_sys_top;
  localparam int unsigned CPB = 16;

`ifdef UART_SYS_TOP_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rx_in, tx_out, stop_error, parity_error, start_glitch;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_glitch = 0, n_stop = 0, n_par = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  uart_sys_top #(.CLKS_PER_BIT(CPB)) dut (
    .Ref_clk     (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .tx_out      (tx_out),
    .stop_error  (stop_error),
    .parity_error(parity_error),
    .start_glitch(start_glitch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [7:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      8'd0:    return 16'(a) + 16'(b);
      8'd1:    return 16'(a) - 16'(b);
      8'd2:    return 16'(a) * 16'(b);
      8'd3:    return (b == 8'h00) ? 16'h0000 : 16'(a / b);
      8'd4:    return 16'(a & b);
      8'd5:    return 16'(a | b);
      8'd6:    return 16'(a ^ b);
      default: return 16'h0000;
    endcase
  endfunction

  // Error pulse counters; a pulse longer than one cycle counts more than once
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (start_glitch) n_glitch++;
      if (stop_error)   n_stop++;
      if (parity_error) n_par++;
    end
  end

  // TX decoder: sample each bit at its middle and compare against the scoreboard
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_out === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx_out;
        end
        if (PAR) begin
          repeat (CPB) @(negedge clk);
          check("tx_parity", 32'(tx_out), 32'(^b));
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop", 32'(tx_out), 32'(1));
        check("tx_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) check("tx_byte", 32'(b), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR) begin
      rx_in = (^d) ^ bad_par;
      repeat (CPB) @(negedge clk);
    end
    rx_in = !bad_stop;
    repeat (CPB) @(negedge clk);
    if (bad_stop) begin
      rx_in = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b0);
  endtask

  task automatic expect_alu(input logic [7:0] lo, input logic [7:0] hi);
    exp_q.push_back(lo);
    exp_q.push_back(hi);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    repeat (14 * CPB) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: ran 95000 cycles, required finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_tx_out", 32'(tx_out), 32'(1));
    check("rst_stop_error", 32'(stop_error), 32'(0));
    check("rst_parity_error", 32'(parity_error), 32'(0));
    check("rst_start_glitch", 32'(start_glitch), 32'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single-cycle low on rx: start glitch, no byte, FSM unaffected
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_pulses", 32'(n_glitch), 32'(1));
    exp_q.push_back(8'h00);
    send(8'hBB); send(8'h05);
    drain("drain_glitch");

    if (PAR) begin
      send_frame(8'hAA, 1'b1, 1'b0);
      send(8'h05); send(8'h19);
      check("parity_pulses", 32'(n_par), 32'(1));
      exp_q.push_back(8'h00);
      send(8'hBB); send(8'h05);
      drain("drain_parity");
    end

    send(8'hAA); send(8'h05); send(8'h19);
    exp_q.push_back(8'h19);
    send(8'hBB); send(8'h05);
    exp_q.push_back(8'h00);
    send(8'hBB); send(8'h02);
    drain("drain_rw");

    expect_alu(8'h1A, 8'h00); send(8'hCC); send(8'h0B); send(8'h0F); send(8'h00);
    expect_alu(8'hFB, 8'hFF); send(8'hCC); send(8'h0A); send(8'h0F); send(8'h01);
    expect_alu(8'h26, 8'h34); send(8'hCC); send(8'h96); send(8'h59); send(8'h02);
    expect_alu(8'h32, 8'h00); send(8'hCC); send(8'hC8); send(8'h04); send(8'h03);
    expect_alu(8'h0A, 8'h00); send(8'hCC); send(8'h0A); send(8'h0F); send(8'h04);
    drain("drain_cc");

    send(8'hAA); send(8'h00); send(8'h7F);
    send(8'hAA); send(8'h01); send(8'hFD);
    expect_alu(8'h7C, 8'h01); send(8'hDD); send(8'h00);
    expect_alu(8'h82, 8'hFF); send(8'hDD); send(8'h01);
    expect_alu(8'h83, 8'h7D); send(8'hDD); send(8'h02);
    expect_alu(8'h00, 8'h00); send(8'hDD); send(8'h03);
    expect_alu(8'h7D, 8'h00); send(8'hDD); send(8'h04);
    for (int f = 5; f < 9; f++) begin
      r = alu_ref(8'(f), 8'h7F, 8'hFD);
      expect_alu(r[7:0], r[15:8]);
      send(8'hDD); send(8'(f));
    end
    drain("drain_dd");

    send(8'hAA); send(8'h01); send(8'h00);
    send_frame(8'hBB, 1'b0, 1'b1);
    check("stop_pulses", 32'(n_stop), 32'(1));
    expect_alu(8'h00, 8'h00); send(8'hDD); send(8'h03);
    drain("drain_stop");

    send(8'hAA); send(8'h03); send(8'h55);
    exp_q.push_back(8'h55);
    send(8'hBB); send(8'h03);
    drain("drain_pre_reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst2_tx_out", 32'(tx_out), 32'(1));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(8'h00);
    send(8'hBB); send(8'h03);
    drain("drain_post_reset");

    check("final_glitch_pulses", 32'(n_glitch), 32'(1));
    check("final_stop_pulses", 32'(n_stop), 32'(1));
    check("final_parity_pulses", 32'(n_par), PAR ? 32'(1) : 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
